lsu_wb_sequencer: RTL and testbench
===================================

# lsu_wb_sequencer

Write-back end of the LSU register-file interface. It accepts the per-instruction descriptor that the read-stage router produces: destination/store-source address, rd_en/wr_en dword masks, wavefront id and exec mask. It then consumes memory response beats and sequences one VGPR or SGPR write per returned dword. Once every beat is accepted it retires the instruction with a one-cycle done pulse to the wavepool/issue logic.

## Interface
- LANES, 64, vector lanes; VGPR write data is LANES*32 bits
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- in_issue_valid  in  1  descriptor valid
- out_issue_ready  out  1  block can accept a descriptor
- in_rd_en  in  4  load dword mask; legal values 0001, 0011, 1111
- in_wr_en  in  4  store dword mask; legal values 0001, 1111
- in_lddst_stsrc_addr  in  12  bit11=valid, bit10=1 SGPR [8:0], bit10=0 VGPR [9:0]
- in_wfid  in  6  wavefront id
- in_exec_mask  in  LANES  lane write mask
- in_mem_rsp_valid  in  1  response beat valid; load beat = one dword, store = single ack beat
- out_mem_rsp_ready  out  1  beat accepted when valid&&ready
- in_mem_rsp_data  in  LANES*32  beat data; SGPR uses [31:0]
- out_vgpr_wr_en  out  1  VGPR write strobe
- out_vgpr_wr_addr  out  10
- out_vgpr_wr_data  out  LANES*32
- out_vgpr_wr_mask  out  LANES
- out_sgpr_wr_en  out  1  SGPR write strobe
- out_sgpr_wr_addr  out  9
- out_sgpr_wr_data  out  32
- out_done  out  1  one-cycle retire pulse
- out_done_wfid  out  6
- out_err  out  1  qualifies out_done; illegal descriptor

## Operation
- States: IDLE, WAIT, DRAIN.
- IDLE: out_issue_ready=1. On in_issue_valid, capture the descriptor and go to WAIT.
  - beats_total = index of highest set bit +1: 0001→1, 0011→2, 1111→4. Taken from rd_en for loads; stores always need 1 ack beat.
  - Clear beat_cnt.
- Illegal descriptor, captured err=1, skips WAIT and goes to DRAIN with no writes:
  - rd_en and wr_en both zero or both nonzero;
  - mask not in the legal set;
  - load with addr bit11=0.
- WAIT: out_mem_rsp_ready=1.
  - Each accepted load beat registers one write into SGPR or VGPR per captured bit10.
  - Write address = base + beat_cnt, modulo 512 (SGPR) or 1024 (VGPR). Wrap is silent.
  - VGPR mask = captured exec mask.
  - beat_cnt increments. On the beat where beat_cnt == beats_total-1, go to DRAIN.
  - Store ack beat produces no write and goes to DRAIN.
- DRAIN: register out_done=1, out_done_wfid, out_err; go to IDLE.
- Never more than one instruction in flight.
- in_mem_rsp_valid outside WAIT is ignored (ready=0).
- Reset at any point: state→IDLE, in-flight instruction dropped with no done.

## Timing
- All outputs registered except out_issue_ready and out_mem_rsp_ready, which are decoded from state.
- Reset values:
  - all strobes, out_done and out_err = 0;
  - addresses, data, mask and wfid outputs = 0;
  - state IDLE.
- Issue accept at cycle T → WAIT at T+1. The earliest beat is accepted at T+1.
- Beat accepted at cycle N → write strobe high exactly in N+1, one cycle per beat.
- Back-to-back beats produce back-to-back writes.
- Last beat at N → out_done in N+2. out_issue_ready high again in N+2, and a new issue is accepted in N+2.
- Illegal issue at T → out_done with out_err=1 at T+2.
- VGPR and SGPR strobes are never high together.

## Structure
- Package lsu_wb_pkg holds:
  - state encoding;
  - dest-field bit positions (valid=11, sgpr_sel=10);
  - legal mask constants;
  - beats-from-mask function.
- One natural sub-module: lsu_wb_dest_decode. It is combinational: captured address + beat_cnt → sgpr_addr, vgpr_addr, sel and valid.
- The FSM, beat counter and output registers live in the top.

## Test plan
- s_load_dwordx4: rd_en=1111, addr=12'hC10 (SGPR 16), beats D0..D3 back-to-back.
  - Expect SGPR writes to 16,17,18,19 with D0..D3 on consecutive cycles.
  - out_done 2 cycles after D3; out_err=0.
- tbuffer_load_format_x: rd_en=0001, addr=12'h805 (VGPR 5), exec=64'h00000000FFFFFFFF.
  - Expect one VGPR write at 5 with that mask, then done.
- tbuffer_store_format_xyzw: wr_en=1111, a single ack beat.
  - Expect no writes; out_done 2 cycles after the ack.
- Wrap: rd_en=1111, VGPR 1022.
  - Expect writes to 1022, 1023, 0, 1.
- Illegal cases, each with out_done+out_err at T+2 and no writes:
  - rd_en=0011 and wr_en=0001 together;
  - rd_en=0101;
  - load to addr 12'h010.
- Robustness: with 1-cycle bubbles between beats, writes track the beats one cycle later. Assert rst_n low after the 2nd of 4 beats: outputs return to reset values, no done, and the next issue behaves normally.

Source files
------------

// File: rtl/lsu_wb_pkg.sv
// Shared definitions for the LSU write-back sequencer: FSM states, dest-field
// layout, legal dword masks and descriptor decode helpers.
package lsu_wb_pkg;

   localparam int LANES          = 64;
   localparam int DEST_VALID_BIT = 11;
   localparam int DEST_SGPR_BIT  = 10;

   localparam logic [3:0] MASK_X    = 4'b0001;
   localparam logic [3:0] MASK_XY   = 4'b0011;
   localparam logic [3:0] MASK_XYZW = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [2:0] beats_from_mask(input logic [3:0] mask);
      if (mask[3]) return 3'd4;
      if (mask[2]) return 3'd3;
      if (mask[1]) return 3'd2;
      if (mask[0]) return 3'd1;
      return 3'd0;
   endfunction

   function automatic logic legal_rd_mask(input logic [3:0] mask);
      return (mask == MASK_X) || (mask == MASK_XY) || (mask == MASK_XYZW);
   endfunction

   function automatic logic legal_wr_mask(input logic [3:0] mask);
      return (mask == MASK_X) || (mask == MASK_XYZW);
   endfunction

   // A descriptor must be exactly one of load or store; loads also need a valid dest.
   function automatic logic desc_illegal(input logic [3:0]  rd_en,
                                         input logic [3:0]  wr_en,
                                         input logic [11:0] addr);
      if ((|rd_en) == (|wr_en)) return 1'b1;
      if (|rd_en) return !legal_rd_mask(rd_en) || !addr[DEST_VALID_BIT];
      return !legal_wr_mask(wr_en);
   endfunction

endpackage

// File: rtl/lsu_wb_sequencer_if.sv
// Issue, memory-response and register-file write bundle of the LSU write-back
// sequencer; the sequencer uses the slave view, its environment the master view.
interface lsu_wb_sequencer_if;
   import lsu_wb_pkg::*;

   logic                  in_issue_valid;
   logic                  out_issue_ready;
   logic [3:0]            in_rd_en;
   logic [3:0]            in_wr_en;
   logic [11:0]           in_lddst_stsrc_addr;
   logic [5:0]            in_wfid;
   logic [LANES-1:0]      in_exec_mask;

   logic                  in_mem_rsp_valid;
   logic                  out_mem_rsp_ready;
   logic [LANES*32-1:0]   in_mem_rsp_data;

   logic                  out_vgpr_wr_en;
   logic [9:0]            out_vgpr_wr_addr;
   logic [LANES*32-1:0]   out_vgpr_wr_data;
   logic [LANES-1:0]      out_vgpr_wr_mask;
   logic                  out_sgpr_wr_en;
   logic [8:0]            out_sgpr_wr_addr;
   logic [31:0]           out_sgpr_wr_data;

   logic                  out_done;
   logic [5:0]            out_done_wfid;
   logic                  out_err;

   modport slave (
      input  in_issue_valid, in_rd_en, in_wr_en, in_lddst_stsrc_addr, in_wfid,
             in_exec_mask, in_mem_rsp_valid, in_mem_rsp_data,
      output out_issue_ready, out_mem_rsp_ready,
             out_vgpr_wr_en, out_vgpr_wr_addr, out_vgpr_wr_data, out_vgpr_wr_mask,
             out_sgpr_wr_en, out_sgpr_wr_addr, out_sgpr_wr_data,
             out_done, out_done_wfid, out_err
   );

   modport master (
      output in_issue_valid, in_rd_en, in_wr_en, in_lddst_stsrc_addr, in_wfid,
             in_exec_mask, in_mem_rsp_valid, in_mem_rsp_data,
      input  out_issue_ready, out_mem_rsp_ready,
             out_vgpr_wr_en, out_vgpr_wr_addr, out_vgpr_wr_data, out_vgpr_wr_mask,
             out_sgpr_wr_en, out_sgpr_wr_addr, out_sgpr_wr_data,
             out_done, out_done_wfid, out_err
   );

endinterface

// File: rtl/lsu_wb_sequencer_dest_decode.sv
// Turns the captured dest field plus the current beat index into SGPR/VGPR
// write addresses; register-file wrap is the natural modulo of the field width.
module lsu_wb_dest_decode
   import lsu_wb_pkg::*;
(
   input  logic [11:0] i_addr,
   input  logic [2:0]  i_beat_cnt,
   output logic [8:0]  o_sgpr_addr,
   output logic [9:0]  o_vgpr_addr,
   output logic        o_sgpr_sel,
   output logic        o_valid
);

   assign o_sgpr_addr = i_addr[8:0] + {6'd0, i_beat_cnt};
   assign o_vgpr_addr = i_addr[9:0] + {7'd0, i_beat_cnt};
   assign o_sgpr_sel  = i_addr[DEST_SGPR_BIT];
   assign o_valid     = i_addr[DEST_VALID_BIT];

endmodule

// File: rtl/lsu_wb_sequencer.sv
// LSU write-back sequencer: captures one instruction descriptor, turns each
// returned load dword into a register-file write, then retires with a done pulse.
module lsu_wb_sequencer (
   input  logic               clk,
   input  logic               rst_n,
   lsu_wb_sequencer_if.slave  bus
);
   import lsu_wb_pkg::*;

   state_t               r_state;
   state_t               w_next_state;
   logic                 w_issue_ready;
   logic                 w_rsp_ready;
   logic                 w_issue_fire;
   logic                 w_beat_fire;
   logic                 w_issue_err;
   logic                 w_last_beat;

   logic [11:0]          r_addr;
   logic [5:0]           r_wfid;
   logic [LANES-1:0]     r_exec;
   logic                 r_err;
   logic                 r_is_load;
   logic [2:0]           r_beats_total;
   logic [2:0]           r_beat_cnt;

   logic [8:0]           w_sgpr_addr;
   logic [9:0]           w_vgpr_addr;
   logic                 w_sgpr_sel;
   logic                 w_dest_valid;

   logic                 r_vgpr_wr_en;
   logic [9:0]           r_vgpr_wr_addr;
   logic [LANES*32-1:0]  r_vgpr_wr_data;
   logic [LANES-1:0]     r_vgpr_wr_mask;
   logic                 r_sgpr_wr_en;
   logic [8:0]           r_sgpr_wr_addr;
   logic [31:0]          r_sgpr_wr_data;
   logic                 r_done;
   logic [5:0]           r_done_wfid;
   logic                 r_done_err;

   assign w_issue_err  = desc_illegal(bus.in_rd_en, bus.in_wr_en, bus.in_lddst_stsrc_addr);
   assign w_issue_fire = w_issue_ready & bus.in_issue_valid;
   assign w_beat_fire  = w_rsp_ready & bus.in_mem_rsp_valid;
   assign w_last_beat  = (r_beat_cnt == r_beats_total - 3'd1);

   lsu_wb_dest_decode u_dest_decode (
      .i_addr      (r_addr),
      .i_beat_cnt  (r_beat_cnt),
      .o_sgpr_addr (w_sgpr_addr),
      .o_vgpr_addr (w_vgpr_addr),
      .o_sgpr_sel  (w_sgpr_sel),
      .o_valid     (w_dest_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // Illegal descriptors bypass WAIT so they retire two cycles after issue.
   always_comb begin
      w_next_state  = r_state;
      w_issue_ready = 1'b0;
      w_rsp_ready   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_issue_ready = 1'b1;
            if (bus.in_issue_valid) w_next_state = w_issue_err ? ST_DRAIN : ST_WAIT;
         end
         ST_WAIT: begin
            w_rsp_ready = 1'b1;
            if (bus.in_mem_rsp_valid && (!r_is_load || w_last_beat)) w_next_state = ST_DRAIN;
         end
         ST_DRAIN: w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr        <= '0;
         r_wfid        <= '0;
         r_exec        <= '0;
         r_err         <= 1'b0;
         r_is_load     <= 1'b0;
         r_beats_total <= '0;
         r_beat_cnt    <= '0;
      end else if (w_issue_fire) begin
         r_addr        <= bus.in_lddst_stsrc_addr;
         r_wfid        <= bus.in_wfid;
         r_exec        <= bus.in_exec_mask;
         r_err         <= w_issue_err;
         r_is_load     <= |bus.in_rd_en;
         r_beats_total <= (|bus.in_rd_en) ? beats_from_mask(bus.in_rd_en) : 3'd1;
         r_beat_cnt    <= '0;
      end else if (w_beat_fire) begin
         r_beat_cnt    <= r_beat_cnt + 3'd1;
      end
   end

   // Strobes are single-cycle; address/data/mask hold their last written values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vgpr_wr_en   <= 1'b0;
         r_vgpr_wr_addr <= '0;
         r_vgpr_wr_data <= '0;
         r_vgpr_wr_mask <= '0;
         r_sgpr_wr_en   <= 1'b0;
         r_sgpr_wr_addr <= '0;
         r_sgpr_wr_data <= '0;
         r_done         <= 1'b0;
         r_done_wfid    <= '0;
         r_done_err     <= 1'b0;
      end else begin
         r_vgpr_wr_en <= 1'b0;
         r_sgpr_wr_en <= 1'b0;
         r_done       <= 1'b0;
         r_done_err   <= 1'b0;
         if (w_beat_fire && r_is_load && w_dest_valid) begin
            if (w_sgpr_sel) begin
               r_sgpr_wr_en   <= 1'b1;
               r_sgpr_wr_addr <= w_sgpr_addr;
               r_sgpr_wr_data <= bus.in_mem_rsp_data[31:0];
            end else begin
               r_vgpr_wr_en   <= 1'b1;
               r_vgpr_wr_addr <= w_vgpr_addr;
               r_vgpr_wr_data <= bus.in_mem_rsp_data;
               r_vgpr_wr_mask <= r_exec;
            end
         end
         if (r_state == ST_DRAIN) begin
            r_done      <= 1'b1;
            r_done_wfid <= r_wfid;
            r_done_err  <= r_err;
         end
      end
   end

   assign bus.out_issue_ready   = w_issue_ready;
   assign bus.out_mem_rsp_ready = w_rsp_ready;
   assign bus.out_vgpr_wr_en    = r_vgpr_wr_en;
   assign bus.out_vgpr_wr_addr  = r_vgpr_wr_addr;
   assign bus.out_vgpr_wr_data  = r_vgpr_wr_data;
   assign bus.out_vgpr_wr_mask  = r_vgpr_wr_mask;
   assign bus.out_sgpr_wr_en    = r_sgpr_wr_en;
   assign bus.out_sgpr_wr_addr  = r_sgpr_wr_addr;
   assign bus.out_sgpr_wr_data  = r_sgpr_wr_data;
   assign bus.out_done          = r_done;
   assign bus.out_done_wfid     = r_done_wfid;
   assign bus.out_err           = r_done_err;

endmodule

// File: tb/tb_lsu_wb_sequencer.sv
// Directed bench for lsu_wb_sequencer: a table of instruction descriptors with
// hand-computed write addresses, plus a mid-flight reset sequence.
module tb_lsu_wb_sequencer;

   logic clk;
   logic rst_n;
   int   cyc;
   int   vecCount;
   int   missCount;
   int   overlapCnt;

   lsu_wb_sequencer_if bus();

   lsu_wb_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string            name;
      logic [3:0]       rdEn;
      logic [3:0]       wrEn;
      logic [11:0]      addr;
      logic [5:0]       wfid;
      logic [63:0]      exec;
      int               beats;
      int               gap;
      logic             expErr;
      int               expKind;
      int               expWrites;
      logic [3:0][9:0]  expAddr;
   } vec_t;

   typedef struct {
      int               kind;
      logic [9:0]       addr;
      logic [2047:0]    data;
      logic [63:0]      mask;
      int               cycle;
   } wr_rec_t;

   wr_rec_t wrQ[$];
   vec_t    vecs[15];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Collect every register-file write with the cycle it was visible in.
   always @(negedge clk) begin
      wr_rec_t r;
      if (bus.out_vgpr_wr_en && bus.out_sgpr_wr_en) overlapCnt <= overlapCnt + 1;
      if (bus.out_vgpr_wr_en) begin
         r.kind = 2; r.addr = bus.out_vgpr_wr_addr; r.data = bus.out_vgpr_wr_data;
         r.mask = bus.out_vgpr_wr_mask; r.cycle = cyc;
         wrQ.push_back(r);
      end
      if (bus.out_sgpr_wr_en) begin
         r.kind = 1; r.addr = {1'b0, bus.out_sgpr_wr_addr};
         r.data = {2016'd0, bus.out_sgpr_wr_data}; r.mask = '0; r.cycle = cyc;
         wrQ.push_back(r);
      end
   end

   function automatic logic [2047:0] beatData(input int v, input int k);
      logic [2047:0] d;
      for (int i = 0; i < 64; i++) d[i*32 +: 32] = {8'(v + 160), 8'(k + 1), 16'(i * 257 + 17)};
      return d;
   endfunction

   function automatic vec_t mkVec(input string name, input logic [3:0] rd, input logic [3:0] wr,
                                  input logic [11:0] addr, input logic [5:0] wfid,
                                  input logic [63:0] exec, input int beats, input int gap,
                                  input logic err, input int kind, input int nw,
                                  input logic [9:0] a0, input logic [9:0] a1,
                                  input logic [9:0] a2, input logic [9:0] a3);
      vec_t t;
      t.name = name; t.rdEn = rd; t.wrEn = wr; t.addr = addr; t.wfid = wfid; t.exec = exec;
      t.beats = beats; t.gap = gap; t.expErr = err; t.expKind = kind; t.expWrites = nw;
      t.expAddr[0] = a0; t.expAddr[1] = a1; t.expAddr[2] = a2; t.expAddr[3] = a3;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic checkWide(input string name, input logic [2047:0] act, input logic [2047:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         for (int i = 0; i < 64; i++) begin
            if (act[i*32 +: 32] !== exp[i*32 +: 32]) begin
               $display("[TB] FAIL %s: lane %0d got %h expected %h", name, i,
                        act[i*32 +: 32], exp[i*32 +: 32]);
               break;
            end
         end
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, ".vgprEn"},   64'(bus.out_vgpr_wr_en),   64'd0);
      checkOutput({tag, ".vgprAddr"}, 64'(bus.out_vgpr_wr_addr), 64'd0);
      checkWide  ({tag, ".vgprData"}, bus.out_vgpr_wr_data,      '0);
      checkOutput({tag, ".vgprMask"}, bus.out_vgpr_wr_mask,      64'd0);
      checkOutput({tag, ".sgprEn"},   64'(bus.out_sgpr_wr_en),   64'd0);
      checkOutput({tag, ".sgprAddr"}, 64'(bus.out_sgpr_wr_addr), 64'd0);
      checkOutput({tag, ".sgprData"}, 64'(bus.out_sgpr_wr_data), 64'd0);
      checkOutput({tag, ".done"},     64'(bus.out_done),         64'd0);
      checkOutput({tag, ".doneWfid"}, 64'(bus.out_done_wfid),    64'd0);
      checkOutput({tag, ".err"},      64'(bus.out_err),          64'd0);
      checkOutput({tag, ".issueRdy"}, 64'(bus.out_issue_ready),  64'd1);
      checkOutput({tag, ".rspRdy"},   64'(bus.out_mem_rsp_ready), 64'd0);
   endtask

   // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
   task automatic applyStimulus(input int v, input vec_t t);
      int      tIssue;
      int      tLast;
      int      tBeat[4];
      int      tDone;
      bit      seen;
      wr_rec_t w;
      logic [2047:0] expData;
      checkOutput({t.name, ".issueReady"}, 64'(bus.out_issue_ready), 64'd1);
      bus.in_issue_valid      = 1'b1;
      bus.in_rd_en            = t.rdEn;
      bus.in_wr_en            = t.wrEn;
      bus.in_lddst_stsrc_addr = t.addr;
      bus.in_wfid             = t.wfid;
      bus.in_exec_mask        = t.exec;
      tIssue = cyc;
      @(negedge clk);
      bus.in_issue_valid      = 1'b0;
      bus.in_rd_en            = 4'b0101;
      bus.in_wr_en            = 4'b0110;
      bus.in_lddst_stsrc_addr = 12'h3A5;
      bus.in_wfid             = 6'h2A;
      bus.in_exec_mask        = 64'h5555_AAAA_0F0F_F0F0;
      checkOutput({t.name, ".donePulseWidth"}, 64'(bus.out_done), 64'd0);
      if (t.beats == 0) begin
         checkOutput({t.name, ".illegalRspRdy"},   64'(bus.out_mem_rsp_ready), 64'd0);
         checkOutput({t.name, ".illegalIssueRdy"}, 64'(bus.out_issue_ready),   64'd0);
      end
      tLast = tIssue;
      for (int k = 0; k < t.beats; k++) begin
         if (k > 0) repeat (t.gap) @(negedge clk);
         checkOutput({t.name, ".rspReady"}, 64'(bus.out_mem_rsp_ready), 64'd1);
         bus.in_mem_rsp_valid = 1'b1;
         bus.in_mem_rsp_data  = beatData(v, k);
         tBeat[k] = cyc;
         tLast    = cyc;
         @(negedge clk);
         bus.in_mem_rsp_valid = 1'b0;
         bus.in_mem_rsp_data  = '1;
      end
      seen = 0;
      tDone = 0;
      for (int i = 0; i < 12 && !seen; i++) begin
         if (bus.out_done) begin seen = 1; tDone = cyc; end
         else @(negedge clk);
      end
      checkOutput({t.name, ".doneSeen"},   64'(seen), 64'd1);
      checkOutput({t.name, ".doneCycle"},  64'(tDone - tLast), 64'd2);
      checkOutput({t.name, ".doneErr"},    64'(bus.out_err), 64'(t.expErr));
      checkOutput({t.name, ".doneWfid"},   64'(bus.out_done_wfid), 64'(t.wfid));
      checkOutput({t.name, ".readyAtDone"}, 64'(bus.out_issue_ready), 64'd1);
      for (int k = 0; k < t.expWrites; k++) begin
         if (wrQ.size() == 0) begin
            checkOutput({t.name, ".writeCount"}, 64'(k), 64'(t.expWrites));
            break;
         end
         w = wrQ.pop_front();
         expData = beatData(v, k);
         if (t.expKind == 1) expData = {2016'd0, expData[31:0]};
         checkOutput({t.name, ".wrKind"},  64'(w.kind), 64'(t.expKind));
         checkOutput({t.name, ".wrAddr"},  64'(w.addr), 64'(t.expAddr[k]));
         checkWide  ({t.name, ".wrData"},  w.data, expData);
         checkOutput({t.name, ".wrMask"},  w.mask, (t.expKind == 2) ? t.exec : 64'd0);
         checkOutput({t.name, ".wrCycle"}, 64'(w.cycle - tBeat[k]), 64'd1);
      end
      checkOutput({t.name, ".extraWrites"}, 64'(wrQ.size()), 64'd0);
      wrQ.delete();
      checkOutput({t.name, ".strobeOverlap"}, 64'(overlapCnt), 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int      pre;
      wr_rec_t w;
      cyc = 0; vecCount = 0; missCount = 0; overlapCnt = 0;
      rst_n = 1'b0;
      bus.in_issue_valid = 1'b0; bus.in_rd_en = '0; bus.in_wr_en = '0;
      bus.in_lddst_stsrc_addr = '0; bus.in_wfid = '0; bus.in_exec_mask = '0;
      bus.in_mem_rsp_valid = 1'b0; bus.in_mem_rsp_data = '0;

      vecs[0]  = mkVec("sLoadX4",     4'hF, 4'h0, 12'hC10, 6'd3,  '1, 4, 0, 1'b0, 1, 4, 10'd16, 10'd17, 10'd18, 10'd19);
      vecs[1]  = mkVec("tbufLoadX",   4'h1, 4'h0, 12'h805, 6'd7,  64'h00000000FFFFFFFF, 1, 0, 1'b0, 2, 1, 10'd5, 10'd0, 10'd0, 10'd0);
      vecs[2]  = mkVec("storeXYZW",   4'h0, 4'hF, 12'h123, 6'd9,  '1, 1, 0, 1'b0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
      vecs[3]  = mkVec("vgprWrap",    4'hF, 4'h0, 12'hBFE, 6'd12, 64'hDEADBEEF01234567, 4, 0, 1'b0, 2, 4, 10'd1022, 10'd1023, 10'd0, 10'd1);
      vecs[4]  = mkVec("sgprWrap",    4'h3, 4'h0, 12'hDFF, 6'd20, '1, 2, 0, 1'b0, 1, 2, 10'd511, 10'd0, 10'd0, 10'd0);
      vecs[5]  = mkVec("sgprBit9",    4'h1, 4'h0, 12'hE05, 6'd33, '1, 1, 0, 1'b0, 1, 1, 10'd5, 10'd0, 10'd0, 10'd0);
      vecs[6]  = mkVec("vgprBubble",  4'hF, 4'h0, 12'h832, 6'd40, 64'hF0F0F0F0F0F0F0F0, 4, 1, 1'b0, 2, 4, 10'd50, 10'd51, 10'd52, 10'd53);
      vecs[7]  = mkVec("storeX",      4'h0, 4'h1, 12'h000, 6'd41, '1, 1, 0, 1'b0, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
      vecs[8]  = mkVec("illBoth",     4'h3, 4'h1, 12'hC10, 6'd50, '1, 0, 0, 1'b1, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
      vecs[9]  = mkVec("illRd0101",   4'h5, 4'h0, 12'h805, 6'd51, '1, 0, 0, 1'b1, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
      vecs[10] = mkVec("illNoValid",  4'h1, 4'h0, 12'h010, 6'd52, '1, 0, 0, 1'b1, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
      vecs[11] = mkVec("illNone",     4'h0, 4'h0, 12'hC10, 6'd53, '1, 0, 0, 1'b1, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
      vecs[12] = mkVec("illWr0011",   4'h0, 4'h3, 12'h805, 6'd54, '1, 0, 0, 1'b1, 0, 0, 10'd0, 10'd0, 10'd0, 10'd0);
      vecs[13] = mkVec("sgprGap2",    4'h3, 4'h0, 12'hC40, 6'd63, '1, 2, 2, 1'b0, 1, 2, 10'd64, 10'd65, 10'd0, 10'd0);
      vecs[14] = mkVec("vgprX2",      4'h3, 4'h0, 12'h800, 6'd1,  64'h1, 2, 0, 1'b0, 2, 2, 10'd0, 10'd1, 10'd0, 10'd0);

      #12;
      checkResetOutputs("powerOnReset");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 15; v++) applyStimulus(v, vecs[v]);

      // Mid-flight reset after two of four beats: the instruction must vanish silently.
      bus.in_issue_valid = 1'b1; bus.in_rd_en = 4'hF; bus.in_wr_en = 4'h0;
      bus.in_lddst_stsrc_addr = 12'h840; bus.in_wfid = 6'd45; bus.in_exec_mask = '1;
      @(negedge clk);
      bus.in_issue_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.in_mem_rsp_valid = 1'b1;
         bus.in_mem_rsp_data  = beatData(90, k);
         @(negedge clk);
         bus.in_mem_rsp_valid = 1'b0;
      end
      @(negedge clk);
      pre = wrQ.size();
      checkOutput("midReset.preWrites", 64'(pre), 64'd2);
      if (pre == 2) begin
         w = wrQ.pop_front();
         checkOutput("midReset.wr0Addr", 64'(w.addr), 64'd64);
         w = wrQ.pop_front();
         checkOutput("midReset.wr1Addr", 64'(w.addr), 64'd65);
      end
      wrQ.delete();
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midReset");
      repeat (2) begin
         @(negedge clk);
         checkOutput("midReset.noDoneInReset", 64'(bus.out_done), 64'd0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_mem_rsp_valid = 1'b1;
         bus.in_mem_rsp_data  = beatData(91, i);
         @(negedge clk);
         checkOutput("idleRsp.rspReady", 64'(bus.out_mem_rsp_ready), 64'd0);
         checkOutput("idleRsp.noDone",   64'(bus.out_done), 64'd0);
      end
      bus.in_mem_rsp_valid = 1'b0;
      checkOutput("idleRsp.noWrites", 64'(wrQ.size()), 64'd0);
      wrQ.delete();

      applyStimulus(0, vecs[0]);
      applyStimulus(1, vecs[1]);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
